// File: rtl/uart_rx_monitor.sv
`timescale 1ns/1ps
// UART 8N1 receiver with line accumulation for the SoC bench.
// Reports each good byte, flags stop-bit errors, and signals completed lines.
module uart_rx_monitor #(
   parameter int unsigned CLKS_PER_BIT = 4167,
   parameter int unsigned LINE_MAX     = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ser_rx,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        frame_err,
   output logic        line_valid,
   output logic [8:0]  line_len,
   input  logic [7:0]  line_rd_addr,
   output logic [7:0]  line_rd_data,
   output logic [15:0] byte_count
);

   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned ADDR_W = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
   localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_MAX - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   logic [1:0]        sync_q;
   logic              rx_s;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tick_c;
   logic              byte_done_c;
   logic              stop_bad_c;
   logic              is_lf_c;
   logic              is_cr_c;
   logic              store_c;
   logic [ADDR_W-1:0] wr_ptr;
   logic [7:0]        mem [LINE_MAX];

   // Two-flop synchronizer; idles high so reset does not look like a start bit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], ser_rx};
      end
   end

   assign rx_s = sync_q[1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   assign tick_c = (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      byte_done_c = 1'b0;
      stop_bad_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               cnt_d   = HALF_LOAD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick_c) begin
               cnt_d = BIT_LOAD;
               if (rx_s) begin
                  state_d = ST_IDLE;
               end else begin
                  bit_idx_d = '0;
                  state_d   = ST_DATA;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (tick_c) begin
               cnt_d     = BIT_LOAD;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (tick_c) begin
               cnt_d = BIT_LOAD;
               if (rx_s) begin
                  byte_done_c = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  stop_bad_c = 1'b1;
                  state_d    = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign is_lf_c = (shift_q == 8'h0A);
   assign is_cr_c = (shift_q == 8'h0D);
   assign store_c = byte_done_c && !is_lf_c && !is_cr_c;

   // Byte reporting, counters and line framing
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         line_valid <= 1'b0;
         line_len   <= '0;
         byte_count <= '0;
         wr_ptr     <= '0;
      end else begin
         rx_valid   <= byte_done_c;
         frame_err  <= stop_bad_c;
         line_valid <= 1'b0;
         if (byte_done_c) begin
            rx_data <= shift_q;
            if (byte_count != 16'hFFFF) begin
               byte_count <= byte_count + 16'd1;
            end
            if (is_lf_c) begin
               line_len   <= 9'(wr_ptr);
               line_valid <= 1'b1;
               wr_ptr     <= '0;
            end else if (store_c) begin
               if (wr_ptr == LAST_ADDR) begin
                  line_len   <= 9'(LINE_MAX);
                  line_valid <= 1'b1;
                  wr_ptr     <= '0;
               end else begin
                  wr_ptr <= wr_ptr + ADDR_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(LINE_MAX); i++) begin
            mem[i] <= '0;
         end
      end else if (store_c) begin
         mem[wr_ptr] <= shift_q;
      end
   end

   assign line_rd_data = (9'(line_rd_addr) < 9'(LINE_MAX)) ? mem[line_rd_addr[ADDR_W-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_monitor.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_monitor: randomized 8N1 frames against a line-queue model.
module tb_uart_rx_monitor;

   localparam int unsigned CPB  = 16;
   localparam int unsigned LMAX = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ser_rx = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        line_valid;
   logic [8:0]  line_len;
   logic [7:0]  line_rd_addr = 8'h00;
   logic [7:0]  line_rd_data;
   logic [15:0] byte_count;

   uart_rx_monitor #(.CLKS_PER_BIT(CPB), .LINE_MAX(LMAX)) dut (
      .clock        (clock),
      .reset        (reset),
      .ser_rx       (ser_rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .frame_err    (frame_err),
      .line_valid   (line_valid),
      .line_len     (line_len),
      .line_rd_addr (line_rd_addr),
      .line_rd_data (line_rd_data),
      .byte_count   (byte_count)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      bit          is_err;
      logic [7:0]  data;
      bit          lv;
      logic [8:0]  llen;
      logic [15:0] cnt;
      int          start;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [7:0]  line_q[$];
   logic [7:0]  model_mem [LMAX];
   bit          model_wr  [LMAX];
   logic [15:0] model_cnt = 16'h0000;
   logic [7:0]  model_last = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Reference model: a line is a queue of bytes; LF closes it, CR is dropped, LMAX forces a wrap
   task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int start);
      exp_t e;
      e.is_err = !stop_ok;
      e.start  = start;
      e.lv     = 1'b0;
      e.llen   = '0;
      if (stop_ok) begin
         model_last = b;
         if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
         if (b == 8'h0A) begin
            e.lv   = 1'b1;
            e.llen = 9'(line_q.size());
            line_q.delete();
         end else if (b != 8'h0D) begin
            model_mem[line_q.size()] = b;
            model_wr[line_q.size()]  = 1'b1;
            line_q.push_back(b);
            if (line_q.size() == int'(LMAX)) begin
               e.lv   = 1'b1;
               e.llen = 9'(LMAX);
               line_q.delete();
            end
         end
      end
      e.data = model_last;
      e.cnt  = model_cnt;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called at a negedge; leaves the line high at a negedge so frames can run back to back
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
      model_byte(b, stop_ok, cyc);
      ser_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         ser_rx = b[i];
         idle(CPB);
      end
      ser_rx = stop_ok;
      idle(CPB);
      if (!stop_ok) idle(extra_low);
      ser_rx = 1'b1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic readback();
      for (int a = 0; a < int'(LMAX); a++) begin
         if (model_wr[a]) begin
            line_rd_addr = 8'(a);
            #1;
            check("line_rd_data", 32'(line_rd_data), 32'(model_mem[a]));
         end
      end
      for (int k = 0; k < 3; k++) begin
         line_rd_addr = 8'($urandom_range(LMAX, 255));
         #1;
         check("line_rd_oob", 32'(line_rd_data), 32'h0);
      end
      @(negedge clock);
   endtask

   // Monitor: every output event pops one expectation
   always @(negedge clock) begin : mon
      exp_t e;
      int   lat;
      if (!reset && (rx_valid || frame_err || line_valid)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event rx_valid=%0b frame_err=%0b line_valid=%0b data=%0h required=none",
                     rx_valid, frame_err, line_valid, rx_data);
         end else begin
            e = exp_q.pop_front();
            check("rx_valid", 32'(rx_valid), 32'(!e.is_err));
            check("frame_err", 32'(frame_err), 32'(e.is_err));
            check("line_valid", 32'(line_valid), 32'(e.lv));
            check("rx_data", 32'(rx_data), 32'(e.data));
            check("byte_count", 32'(byte_count), 32'(e.cnt));
            if (e.lv) check("line_len", 32'(line_len), 32'(e.llen));
            lat = cyc - e.start;
            checks++;
            if (lat < 151 || lat > 155) begin
               errors++;
               $display("FAIL latency actual=%0d required=151..155", lat);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] ok_s [4];
      logic [7:0] b;
      logic [7:0] part;
      bit         good;
      ok_s = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
      for (int a = 0; a < int'(LMAX); a++) begin
         model_mem[a] = 8'h00;
         model_wr[a]  = 1'b0;
      end

      reset = 1'b1;
      idle(5);
      reset = 1'b0;
      @(negedge clock);
      check("rst_rx_data", 32'(rx_data), 32'h0);
      check("rst_rx_valid", 32'(rx_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_line_valid", 32'(line_valid), 32'h0);
      check("rst_line_len", 32'(line_len), 32'h0);
      check("rst_byte_count", 32'(byte_count), 32'h0);

      idle(1000);
      check("idle_byte_count", 32'(byte_count), 32'h0);
      check("idle_rx_data", 32'(rx_data), 32'h0);

      send_frame(8'h41, 1'b1, 0);
      drain();
      check("single_byte_count", 32'(byte_count), 32'd1);

      for (int i = 0; i < 4; i++) send_frame(ok_s[i], 1'b1, 0);
      drain();
      readback();

      ser_rx = 1'b0;
      idle(4);
      ser_rx = 1'b1;
      idle(100);
      check("glitch_byte_count", 32'(byte_count), 32'(model_cnt));

      send_frame(8'h55, 1'b0, 40);
      idle(2 * CPB);
      send_frame(8'h33, 1'b1, 0);
      send_frame(8'h0A, 1'b1, 0);
      drain();

      for (int i = 0; i < 9; i++) send_frame(8'(8'h30 + i), 1'b1, 0);
      drain();
      readback();

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       b = 8'h0A;
            1:       b = 8'h0D;
            default: b = 8'($urandom);
         endcase
         good = ($urandom_range(0, 9) != 0);
         send_frame(b, good, int'($urandom_range(0, 30)));
         if (!good) idle(CPB);
         idle(int'($urandom_range(0, 20)));
      end
      drain();
      readback();

      part = 8'hC6;
      ser_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         ser_rx = part[i];
         idle(CPB);
      end
      reset = 1'b1;
      line_q.delete();
      model_cnt  = 16'h0000;
      model_last = 8'h00;
      for (int a = 0; a < int'(LMAX); a++) model_wr[a] = 1'b0;
      idle(3);
      ser_rx = 1'b1;
      reset  = 1'b0;
      idle(2 * CPB);
      check("midrst_byte_count", 32'(byte_count), 32'h0);
      check("midrst_rx_data", 32'(rx_data), 32'h0);
      send_frame(8'h5A, 1'b1, 0);
      drain();
      check("post_rst_byte_count", 32'(byte_count), 32'd1);
      readback();

      idle(50);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Clock-driven UART receiver and line monitor for the SoC bench; it watches the serial TX pin of the management core (mprj_io[6]).
- Decodes 8N1 frames and reports each received byte.
- Accumulates bytes into a line buffer and flags completed lines, so the bench can report firmware messages and test progress.

Parameters:
- CLKS_PER_BIT, 4167, system clocks per UART bit (40 MHz / 9600 baud); legal values are 4 or more.
- LINE_MAX, 64, line buffer depth in bytes; legal values are 2 to 256.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- ser_rx  input  1  serial data; idles high.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- frame_err  output  1  one-cycle pulse; stop bit was sampled low.
- line_valid  output  1  one-cycle pulse; a line is complete.
- line_len  output  9  number of bytes in the completed line; excludes the 0x0A terminator.
- line_rd_addr  input  8  read index into the line buffer.
- line_rd_data  output  8  combinational read of the line buffer at line_rd_addr.
- byte_count  output  16  total good bytes received; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs, counters, FSM state and buffer write pointer go to 0. FSM enters IDLE. Synchronizer flops reset to 1. Reset asserted mid-frame discards the partial byte and the partial line.
- Input synchronizer: ser_rx passes through 2 flops; the FSM uses only the synchronized value (rx_s).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rx_s == 0, load baud counter = CLKS_PER_BIT/2 - 1 (integer division) and go to START.
- Baud counter counts down once per clock. An event occurs when it reaches 0; the counter then reloads CLKS_PER_BIT - 1.
- START event: if rx_s == 1 it is a glitch; return to IDLE with no output. Otherwise clear bit index and go to DATA.
- DATA event: shift rx_s into bit[index], LSB first. After bit 7 go to STOP.
- STOP event, rx_s == 1: register rx_data, pulse rx_valid on the next clock, increment byte_count (saturating), go to IDLE.
- STOP event, rx_s == 0: pulse frame_err, keep rx_data unchanged, drop the byte, go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. A new frame cannot start until the line has been high for at least one clock.
- Latency: stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after rx_s falls. rx_valid is high exactly 1 clock later.
- Back-to-back frames: a start bit may begin the clock after the STOP→IDLE transition; no bytes are lost at full baud rate.
- Line buffer, byte == 0x0A:
  - Set line_len = write pointer.
  - Pulse line_valid in the same cycle as rx_valid.
  - Reset the write pointer to 0.
- Line buffer, byte == 0x0D: ignored; not stored, no line event.
- Line buffer, any other byte:
  - Store at the write pointer and increment it.
  - If the pointer reaches LINE_MAX, set line_len = LINE_MAX, pulse line_valid and reset the pointer (forced wrap).
- Buffer contents persist until overwritten. line_rd_data for an address ≥ LINE_MAX returns 0.
- frame_err does not affect the line buffer.
- rx_valid, frame_err and line_valid never assert together except for the rx_valid/line_valid pair.

Test Plan (CLKS_PER_BIT=16, LINE_MAX=8):
- Reset then idle-high line for 1000 clocks → rx_valid never pulses; byte_count=0; all outputs 0.
- Send frame 0x41 → one rx_valid pulse 153 ±2 clocks after the falling edge; rx_data=0x41; byte_count=1.
- Send "OK\r\n" back-to-back → three rx_valid pulses for 'O', 'K' and 0x0A, plus a fourth rx_valid for 0x0D. One line_valid arrives with the 0x0A; line_len=2; buffer[0]=0x4F, buffer[1]=0x4B.
- Low glitch of 4 clocks on the idle line → no rx_valid or frame_err; FSM back in IDLE.
- Frame 0x55 with the stop bit driven low, line held low 40 clocks, then high → one frame_err pulse; no rx_valid; byte_count unchanged. The next 0x33 frame is received correctly.
- Nine non-newline bytes 0x30..0x38 → line_valid after the 8th with line_len=8. Byte 0x38 is stored at buffer[0].
- Assert reset at bit 4 of a frame, release, send 0x5A → only 0x5A reported; byte_count=1.
